// File: rtl/eth_tx_pkt_reader.sv
// TX packet reader: pops one queued packet from a FWFT byte FIFO and emits a GMII frame
// (preamble, SFD, payload, optional pad, inter-frame gap). Macro TX_PAD_EN enables padding.
module eth_tx_pkt_reader #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
`ifdef TX_PAD_EN
  ,
  parameter int MIN_FRAME    = 60,
  parameter int CNT_W        = 11
`endif
) (
  input  logic       eth_tx_clk,
  input  logic       rst,
  input  logic [1:0] bf_in_buffer_ready,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_rd_last,
  input  logic       fifo_rd_empty,
  output logic       fifo_rd_en,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       bf_out_pct_txed,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
`ifdef TX_PAD_EN
    PAD,
`endif
    IFG
  } state_t;

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
  // The IDLE cycle that re-samples the ready count is the last gap cycle, so
  // IFG itself lasts one cycle less and frames are exactly IFG_CYCLES apart.
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 2);

  state_t           state, state_d;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_d;
  logic [IFG_W-1:0] ifg_cnt, ifg_cnt_d;
  logic             frame_bad, frame_bad_d;
  logic [7:0]       txd_d;
  logic             tx_en_d, pct_d, und_d, pop;

`ifdef TX_PAD_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME);

  logic [CNT_W-1:0] byte_cnt, byte_cnt_d, byte_cnt_inc;

  assign byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 1'b1;
`endif

  // A pop in the reset cycle would discard a byte the next frame still needs.
  assign fifo_rd_en = pop & ~rst;
  assign busy       = (state != IDLE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d     = state;
    pre_cnt_d   = pre_cnt;
    ifg_cnt_d   = '0;
    frame_bad_d = frame_bad;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    pct_d       = 1'b0;
    und_d       = 1'b0;
    pop         = 1'b0;
`ifdef TX_PAD_EN
    byte_cnt_d  = byte_cnt;
`endif
    case (state)
      IDLE: begin
        pre_cnt_d   = '0;
        frame_bad_d = 1'b0;
        if (bf_in_buffer_ready != 2'd0) state_d = PRE;
      end
      PRE: begin
        txd_d     = 8'h55;
        tx_en_d   = 1'b1;
        pre_cnt_d = pre_cnt + 1'b1;
        if (pre_cnt == PRE_LAST) state_d = SFD;
      end
      SFD: begin
        txd_d   = 8'hD5;
        tx_en_d = 1'b1;
`ifdef TX_PAD_EN
        byte_cnt_d = '0;
`endif
        state_d = DATA;
      end
      DATA: begin
        if (fifo_rd_empty) begin
          und_d       = 1'b1;
          frame_bad_d = 1'b1;
          state_d     = IFG;
        end else begin
          pop     = 1'b1;
          txd_d   = fifo_rd_data;
          tx_en_d = 1'b1;
`ifdef TX_PAD_EN
          byte_cnt_d = byte_cnt_inc;
          if (fifo_rd_last) state_d = (byte_cnt_inc < MIN_CNT) ? PAD : IFG;
`else
          if (fifo_rd_last) state_d = IFG;
`endif
        end
      end
`ifdef TX_PAD_EN
      PAD: begin
        tx_en_d    = 1'b1;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc >= MIN_CNT) state_d = IFG;
      end
`endif
      IFG: begin
        pct_d     = (ifg_cnt == '0) && !frame_bad;
        ifg_cnt_d = ifg_cnt + 1'b1;
        if (ifg_cnt == IFG_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eth_tx_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      ifg_cnt         <= '0;
      frame_bad       <= 1'b0;
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      bf_out_pct_txed <= 1'b0;
      tx_underrun     <= 1'b0;
`ifdef TX_PAD_EN
      byte_cnt        <= '0;
`endif
    end else begin
      state           <= state_d;
      pre_cnt         <= pre_cnt_d;
      ifg_cnt         <= ifg_cnt_d;
      frame_bad       <= frame_bad_d;
      gmii_txd        <= txd_d;
      gmii_tx_en      <= tx_en_d;
      bf_out_pct_txed <= pct_d;
      tx_underrun     <= und_d;
`ifdef TX_PAD_EN
      byte_cnt        <= byte_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_reader.sv
// Self-checking bench for eth_tx_pkt_reader: FWFT FIFO model, per-cycle capture of the
// GMII side, table of single-frame vectors plus back-to-back, underrun and reset sequences.
module tb_eth_tx_pkt_reader;

  logic       eth_tx_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bf_in_buffer_ready = 2'd0;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_last;
  logic       fifo_rd_empty;
  logic       fifo_rd_en;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       bf_out_pct_txed;
  logic       tx_underrun;
  logic       busy;

  always #5 eth_tx_clk = ~eth_tx_clk;

  eth_tx_pkt_reader dut (
    .eth_tx_clk        (eth_tx_clk),
    .rst               (rst),
    .bf_in_buffer_ready(bf_in_buffer_ready),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_last      (fifo_rd_last),
    .fifo_rd_empty     (fifo_rd_empty),
    .fifo_rd_en        (fifo_rd_en),
    .gmii_txd          (gmii_txd),
    .gmii_tx_en        (gmii_tx_en),
    .bf_out_pct_txed   (bf_out_pct_txed),
    .tx_underrun       (tx_underrun),
    .busy              (busy)
  );

  // FWFT FIFO model; lim_on forces empty once pop_cnt reaches lim.
  logic [7:0] fmem [1024];
  bit         flast[1024];
  int         wr_ptr = 0, rd_ptr = 0, pop_cnt = 0, lim = 0;
  bit         lim_on = 1'b0;

  assign fifo_rd_data  = fmem[rd_ptr[9:0]];
  assign fifo_rd_last  = flast[rd_ptr[9:0]];
  assign fifo_rd_empty = (rd_ptr == wr_ptr) || (lim_on && (pop_cnt >= lim));

  always @(posedge eth_tx_clk) begin
    if (fifo_rd_en) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_pkt(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      fmem[wr_ptr[9:0]]  = 8'(base + i);
      flast[wr_ptr[9:0]] = (i == len - 1);
      wr_ptr++;
    end
  endtask

  // Expected tx_en byte stream
  logic [7:0] e_s[1024];
  int         e_n;

  function automatic int pad_to(input int n);
`ifdef TX_PAD_EN
    return (n < 60) ? 60 : n;
`else
    return n;
`endif
  endfunction

  task automatic exp_frame(input int base, input int n);
    for (int i = 0; i < 7; i++) begin e_s[e_n] = 8'h55; e_n++; end
    e_s[e_n] = 8'hD5; e_n++;
    for (int i = 0; i < pad_to(n); i++) begin
      e_s[e_n] = (i < n) ? 8'(base + i) : 8'h00;
      e_n++;
    end
  endtask

  // Per-cycle capture, sampled on the falling edge
  logic [7:0] c_txd[1024];
  bit         c_en[1024], c_pct[1024], c_und[1024], c_busy[1024];
  int         c_n;

  task automatic capture(input int n);
    c_n = 0;
    repeat (n) begin
      @(negedge eth_tx_clk);
      c_txd[c_n]  = gmii_txd;
      c_en[c_n]   = gmii_tx_en;
      c_pct[c_n]  = bf_out_pct_txed;
      c_und[c_n]  = tx_underrun;
      c_busy[c_n] = busy;
      if (bf_out_pct_txed && bf_in_buffer_ready != 2'd0)
        bf_in_buffer_ready = bf_in_buffer_ready - 2'd1;
      c_n++;
    end
  endtask

  int a_en, a_first, a_last, a_runs, a_gap, a_pct, a_pct_idx, a_und, a_und_idx, a_mism;

  task automatic analyze();
    int k;
    k = 0;
    a_en = 0; a_first = -1; a_last = -1; a_runs = 0; a_gap = -1;
    a_pct = 0; a_pct_idx = -1; a_und = 0; a_und_idx = -1; a_mism = 0;
    for (int i = 0; i < c_n; i++) begin
      if (c_en[i]) begin
        if (i == 0 || !c_en[i-1]) begin
          a_runs++;
          if (a_last >= 0 && a_gap < 0) a_gap = i - a_last - 1;
        end
        if (a_first < 0) a_first = i;
        a_last = i;
        a_en++;
        if (k >= e_n || c_txd[i] !== e_s[k]) a_mism++;
        k++;
      end
      if (c_pct[i]) begin a_pct++; if (a_pct_idx < 0) a_pct_idx = i; end
      if (c_und[i]) begin a_und++; if (a_und_idx < 0) a_und_idx = i; end
    end
    if (k < e_n) a_mism += e_n - k;
  endtask

  typedef struct {
    int len;
    int base;
    int exp_en;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit hit;
`ifdef TX_PAD_EN
    vecs[0] = '{64, 8'h00, 72};
    vecs[1] = '{10, 8'hA0, 68};
    vecs[2] = '{ 1, 8'h7E, 68};
    vecs[3] = '{60, 8'h10, 68};
    vecs[4] = '{59, 8'hC3, 68};
`else
    vecs[0] = '{64, 8'h00, 72};
    vecs[1] = '{10, 8'hA0, 18};
    vecs[2] = '{ 1, 8'h7E,  9};
    vecs[3] = '{60, 8'h10, 68};
    vecs[4] = '{59, 8'hC3, 67};
`endif

    // Reset held 3 cycles with a frame available
    rst = 1'b1;
    bf_in_buffer_ready = 2'd1;
    repeat (3) begin
      @(negedge eth_tx_clk);
      check("rst_quiet", {gmii_tx_en, fifo_rd_en, bf_out_pct_txed, busy}, 0);
      check("rst_txd", gmii_txd, 0);
    end

    // Single-frame vectors; the first one starts as reset is released
    for (int v = 0; v < 5; v++) begin
      load_pkt(vecs[v].len, vecs[v].base);
      e_n = 0;
      exp_frame(vecs[v].base, vecs[v].len);
      p0 = pop_cnt;
      if (v == 0) rst = 1'b0;
      bf_in_buffer_ready = 2'd1;
      capture(vecs[v].exp_en + 24);
      analyze();
      check($sformatf("v%0d_first_en", v), a_first, 1);
      check($sformatf("v%0d_en_cycles", v), a_en, vecs[v].exp_en);
      check($sformatf("v%0d_runs", v), a_runs, 1);
      check($sformatf("v%0d_stream_err", v), a_mism, 0);
      check($sformatf("v%0d_pct_cnt", v), a_pct, 1);
      check($sformatf("v%0d_pct_idx", v), a_pct_idx, a_last + 1);
      check($sformatf("v%0d_und_cnt", v), a_und, 0);
      check($sformatf("v%0d_pops", v), pop_cnt - p0, vecs[v].len);
      check($sformatf("v%0d_idle_end", v), int'(c_busy[c_n-1]), 0);
    end

    // Two queued packets back to back
    load_pkt(64, 8'h40);
    load_pkt(64, 8'h80);
    e_n = 0;
    exp_frame(8'h40, 64);
    exp_frame(8'h80, 64);
    p0 = pop_cnt;
    bf_in_buffer_ready = 2'd2;
    capture(190);
    analyze();
    check("b2b_runs", a_runs, 2);
    check("b2b_gap", a_gap, 12);
    check("b2b_en_cycles", a_en, 144);
    check("b2b_stream_err", a_mism, 0);
    check("b2b_pct_cnt", a_pct, 2);
    check("b2b_pops", pop_cnt - p0, 128);
    check("b2b_idle_end", int'(c_busy[c_n-1]), 0);

    // FIFO runs dry after 5 of 10 payload bytes
    load_pkt(10, 8'h20);
    lim = pop_cnt + 5;
    lim_on = 1'b1;
    e_n = 0;
    for (int i = 0; i < 7; i++) begin e_s[e_n] = 8'h55; e_n++; end
    e_s[e_n] = 8'hD5; e_n++;
    for (int i = 0; i < 5; i++) begin e_s[e_n] = 8'(8'h20 + i); e_n++; end
    p0 = pop_cnt;
    bf_in_buffer_ready = 2'd1;
    @(negedge eth_tx_clk);
    bf_in_buffer_ready = 2'd0;
    capture(40);
    analyze();
    check("und_en_cycles", a_en, 13);
    check("und_stream_err", a_mism, 0);
    check("und_cnt", a_und, 1);
    check("und_idx", a_und_idx, a_last + 1);
    check("und_pct_cnt", a_pct, 0);
    check("und_pops", pop_cnt - p0, 5);
    check("und_idle_end", int'(c_busy[c_n-1]), 0);

    // The rest of that packet goes out as its own frame
    lim_on = 1'b0;
    e_n = 0;
    exp_frame(8'h25, 5);
    p0 = pop_cnt;
    bf_in_buffer_ready = 2'd1;
    capture(pad_to(5) + 8 + 24);
    analyze();
    check("tail_en_cycles", a_en, pad_to(5) + 8);
    check("tail_stream_err", a_mism, 0);
    check("tail_pct_cnt", a_pct, 1);
    check("tail_pops", pop_cnt - p0, 5);

    // Reset while the 3rd payload byte is on the wire
    load_pkt(20, 8'h90);
    p0 = pop_cnt;
    bf_in_buffer_ready = 2'd1;
    hit = 1'b0;
    a_en = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge eth_tx_clk);
      if (gmii_tx_en) a_en++;
      if (a_en == 11) begin
        hit = 1'b1;
        check("rst_3rd_byte", gmii_txd, 8'h92);
        rst = 1'b1;
      end
    end
    check("rst_reached", int'(hit), 1);
    repeat (3) begin
      @(negedge eth_tx_clk);
      check("rst_mid_quiet", {gmii_tx_en, fifo_rd_en, bf_out_pct_txed, tx_underrun}, 0);
    end
    check("rst_mid_pops", pop_cnt - p0, 3);
    e_n = 0;
    exp_frame(8'h93, 17);
    p0 = pop_cnt;
    rst = 1'b0;
    capture(pad_to(17) + 8 + 24);
    analyze();
    check("rst_rel_first_en", a_first, 1);
    check("rst_rel_stream_err", a_mism, 0);
    check("rst_rel_pct_cnt", a_pct, 1);
    check("rst_rel_pops", pop_cnt - p0, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
